mem_io_responder: RTL
=====================

// Module: mem_io_responder
// PURPOSE
//  Bus-side responder for the CPU's byte-wide memory port (address, write-enable, data out, data in).
//  Provides RAM and the memory-mapped I/O window, which holds UART RX/TX byte FIFOs, a cycle counter and a stop flag.
//  Drives the CPU's rdy input so the CPU freezes while an I/O access cannot complete.
//  Sits between the CPU top and the board-level UART/host link.
// PARAMETERS
//  RAM_ADDR_W   17  RAM address width in bits; RAM size is 2**RAM_ADDR_W bytes (128 KB)
//  FIFO_DEPTH   16  entries in each of the RX and TX FIFOs; must be a power of 2, >= 2
// PORTS
//  clk_in     in   1   system clock; all state updates on the rising edge
//  rst_in     in   1   synchronous reset, active-high
//  cpu_a      in   32  byte address from the CPU; only [17:0] are decoded
//  cpu_wr     in   1   1 = write, 0 = read
//  cpu_dout   in   8   write data from the CPU
//  cpu_din    out  8   registered read data to the CPU
//  rdy_out    out  1   to the CPU's rdy_in; 0 freezes the CPU
//  rx_valid   in   1   host offers an input byte
//  rx_data    in   8   input byte
//  rx_ready   out  1   RX FIFO accepts the byte (= RX FIFO not full)
//  tx_valid   out  1   TX FIFO not empty
//  tx_data    out  8   head byte of the TX FIFO
//  tx_ready   in   1   sink consumes tx_data this cycle when tx_valid=1
//  stop_o     out  1   sticky program-stop flag
// BEHAVIOUR
//  Decode: io = (cpu_a[17:16]==2'b11). Otherwise the access is a RAM access at cpu_a[RAM_ADDR_W-1:0].
//  The block commits an access only in a cycle where rdy_out=1. When rdy_out=0 it has no side effects.
//  RAM read: address presented in cycle N; cpu_din holds ram[addr] in cycle N+1 (one registered stage).
//  RAM write: ram[addr] <= cpu_dout at the edge that ends cycle N. A read of the same address in N+1 returns the new value.
//  IO read 0x30000: pops the RX head; cpu_din = popped byte in N+1.
//  IO write 0x30000: pushes cpu_dout to the TX FIFO. A value of 0x00 is dropped; no push, no stall.
//  IO read 0x30004: snapshots cyc_cnt; cpu_din = snap[7:0] in N+1.
//  IO read 0x30005/6/7: return snap[15:8] / [23:16] / [31:24] of the last snapshot; no new snapshot is taken.
//  IO write 0x30004: stop_o <= 1. It stays 1 until reset. Data is ignored.
//  Other IO addresses: reads return 0x00, writes are ignored.
//  cyc_cnt: 32 bits, cleared by reset, +1 every cycle and independent of rdy_out. Wraps 0xFFFFFFFF -> 0.
//  rdy_out (combinational) = !(io read 0x30000 && rx_empty) && !(io write 0x30000 && data!=0 && tx_full).
//  While stalled, cpu_din holds its previous value. The access completes in the first cycle the condition clears.
//  Bus contract: the CPU presents each IO access for exactly one rdy_out=1 cycle. A repeated address means a new access.
//  RX FIFO:
//   - push when rx_valid && rx_ready.
//   - rx_ready = !rx_full. There is no pass-through when full, even if a pop occurs in the same cycle.
//   - Push and pop together when non-empty and non-full: the count is unchanged.
//  TX FIFO:
//   - pop when tx_valid && tx_ready.
//   - tx_data is valid whenever tx_valid=1.
//   - A push and a pop in the same cycle on a full FIFO is not allowed, because rdy_out=0 blocks the push.
//   - A push and a pop together at any other fill level: the count is unchanged.
//  FIFO pointers: log2(FIFO_DEPTH)+1 bits, with the wrap bit used for full/empty detection.
//  Reset values:
//   - cpu_din=0x00, rdy_out=1 (given an idle bus), rx_ready=1, tx_valid=0, tx_data=0x00, stop_o=0.
//   - cyc_cnt=0, snap=0, both FIFOs empty.
//   - RAM contents are not reset.
//  Reset mid-stall: FIFOs are flushed, any pending access is dropped, rdy_out is recomputed from the empty FIFOs.
//  stop_o does not stop cyc_cnt or the TX drain.
// TESTING
//  1. Write 0xA5 to 0x01234, then read 0x01234 on the next cycle -> cpu_din=0xA5 one cycle after the read; rdy_out stays 1.
//  2. Read 0x30000 with RX empty -> rdy_out=0 until rx_valid=1 with rx_data=0x41 is accepted; next cycle rdy_out=1, and the following cycle cpu_din=0x41.
//  3. Write 0x00, 0x48, 0x49 to 0x30000 with tx_ready=0 -> 2 TX entries; with tx_ready=1, the sink sees 0x48 then 0x49, then tx_valid=0.
//  4. Fill TX to FIFO_DEPTH, then write 0x30 to 0x30000 -> rdy_out=0; one tx_ready pulse -> push completes the next cycle, count stays FIFO_DEPTH.
//  5. Run 100 cycles after reset, read 0x30004 then 0x30005 -> bytes match the snapshot, e.g. 0x64/0x00 ±1 cycle of issue; 0x30005 taken later still returns the snapshot.
//  6. Write 0x30004 -> stop_o=1 next cycle and stays 1; rst_in=1 -> stop_o=0, FIFOs empty, cpu_din=0x00.

Source files
------------

// File: rtl/mem_io_responder.sv
// Generic byte FIFO with an extra wrap bit on each pointer to tell full from empty.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: push ignored while full (no pass-through), pop ignored while empty.
module mem_io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// CPU byte-port responder: RAM plus an I/O window with UART FIFOs, cycle counter and stop flag.
// Latency: one registered stage from a committed read to cpu_din.
// Backpressure: rdy_out drops while an RX pop finds it empty or a TX push finds it full.
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        rdy_out,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        stop_o
);
    localparam logic [15:0] OFS_UART = 16'h0000;
    localparam logic [15:0] OFS_CNT0 = 16'h0004;
    localparam logic [15:0] OFS_CNT1 = 16'h0005;
    localparam logic [15:0] OFS_CNT2 = 16'h0006;
    localparam logic [15:0] OFS_CNT3 = 16'h0007;

    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  io;
    logic [15:0]           io_ofs;
    logic                  io_rd_rx;
    logic                  io_wr_tx;
    logic                  tx_push_req;
    logic                  io_rd_cnt0;
    logic                  io_wr_stop;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  tx_full;
    logic                  tx_empty;
    logic [7:0]            rx_head;
    logic [7:0]            tx_head;
    logic [31:0]           cyc_cnt;
    logic [31:0]           snap;
    logic [7:0]            rd_byte;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^cpu_a[31:18];

    assign io          = (cpu_a[17:16] == 2'b11);
    assign io_ofs      = cpu_a[15:0];
    assign ram_addr    = cpu_a[RAM_ADDR_W-1:0];
    assign io_rd_rx    = io && !cpu_wr && (io_ofs == OFS_UART);
    assign io_wr_tx    = io &&  cpu_wr && (io_ofs == OFS_UART);
    assign tx_push_req = io_wr_tx && (cpu_dout != 8'h00);
    assign io_rd_cnt0  = io && !cpu_wr && (io_ofs == OFS_CNT0);
    assign io_wr_stop  = io &&  cpu_wr && (io_ofs == OFS_CNT0);

    // Zero bytes written to the TX port are dropped, so they never stall on a full FIFO.
    assign rdy_out = !(io_rd_rx && rx_empty) && !(tx_push_req && tx_full);

    mem_io_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push     (rx_valid),
        .push_dat (rx_data),
        .pop      (rdy_out && io_rd_rx),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    mem_io_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push     (rdy_out && tx_push_req),
        .push_dat (cpu_dout),
        .pop      (tx_ready),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_valid ? tx_head : 8'h00;

    always_comb begin
        rd_byte = 8'h00;
        if (io) begin
            case (io_ofs)
                OFS_UART: rd_byte = rx_head;
                OFS_CNT0: rd_byte = cyc_cnt[7:0];
                OFS_CNT1: rd_byte = snap[15:8];
                OFS_CNT2: rd_byte = snap[23:16];
                OFS_CNT3: rd_byte = snap[31:24];
                default:  rd_byte = 8'h00;
            endcase
        end else begin
            rd_byte = ram[ram_addr];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_out && !io && cpu_wr) ram[ram_addr] <= cpu_dout;
    end

    // cyc_cnt free-runs regardless of stalls or the stop flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cyc_cnt <= '0;
            snap    <= '0;
            stop_o  <= 1'b0;
            cpu_din <= 8'h00;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (rdy_out) begin
                if (!cpu_wr)    cpu_din <= rd_byte;
                if (io_rd_cnt0) snap    <= cyc_cnt;
                if (io_wr_stop) stop_o  <= 1'b1;
            end
        end
    end
endmodule
